// File: rtl/io_key_conditioner_pkg.sv
// Shared types and key indices for the panel key conditioner.
package io_key_conditioner_pkg;

    localparam int unsigned KEY_NUM = 3;
    localparam int unsigned KEY_CH  = 0;
    localparam int unsigned KEY_CE  = 1;
    localparam int unsigned KEY_CP  = 2;

    typedef logic [KEY_NUM-1:0] KeyVector;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } KeyState;

endpackage

// File: rtl/io_key_channel.sv
// One key: synchronizer, debounce FSM and registered level/press/release outputs.
// Auto-repeat of the press pulse is built only when IO_KEY_AUTOREPEAT_EN is defined.
module io_key_channel
    import io_key_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be within 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    KeyState          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef IO_KEY_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
`endif

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef IO_KEY_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (sync_out) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync_out) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_out) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync_out) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);

`ifdef IO_KEY_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        // Only an uninterrupted stay in PRESSED advances the repeat timer.
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                press_d     = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end
`endif
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/io_key_conditioner.sv
// Conditions the three raw panel keys (CH, CE, CP) into clean level and pulse vectors.
// Optional auto-repeat of keyPress: define IO_KEY_AUTOREPEAT_EN.
module io_key_conditioner
    import io_key_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sigCH,
    input  logic               sigCE,
    input  logic               sigCP,
    output logic [KEY_NUM-1:0] keyLevel,
    output logic [KEY_NUM-1:0] keyPress,
    output logic [KEY_NUM-1:0] keyRelease
);

    KeyVector raw;

    assign raw[KEY_CH] = sigCH;
    assign raw[KEY_CE] = sigCE;
    assign raw[KEY_CP] = sigCP;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        io_key_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .pin          (raw[i]),
            .level        (keyLevel[i]),
            .press        (keyPress[i]),
            .release_pulse(keyRelease[i])
        );
    end

endmodule

// File: doc/io_key_conditioner.md
Name: io_key_conditioner

Overview:
- Input front-end that sits directly upstream of the IO controller on the three raw panel keys (sigCH, sigCE, sigCP).
- Per key: synchronizes the asynchronous pin into the system clock domain, debounces it, and produces a clean level plus one-cycle press and release pulses.
- The IO controller consumes only these conditioned signals, never the raw pins.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth (legal range 2..4)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a transition (minimum 1; 250000 on board)
REPEAT_DELAY, 500000, cycles held before the first auto-repeat pulse (used only with AUTOREPEAT_EN)
REPEAT_PERIOD, 100000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN)

Ports:
clk  in  1  system clock; the one clock of the block
rst  in  1  reset; synchronous, active-high
sigCH  in  1  raw key CH, asynchronous, 1 = pressed
sigCE  in  1  raw key CE, asynchronous, 1 = pressed
sigCP  in  1  raw key CP, asynchronous, 1 = pressed
keyLevel  out  3  debounced level; bit 0 = CH, bit 1 = CE, bit 2 = CP
keyPress  out  3  one-cycle pulse on accepted press, same bit mapping
keyRelease  out  3  one-cycle pulse on accepted release, same bit mapping

Behaviour:
- Reset values: all synchronizer flops 0; every channel in RELEASED; counters 0; keyLevel, keyPress and keyRelease all 0.
- All outputs are registered.
- Channels are fully independent; simultaneous events on several keys produce simultaneous pulses.
- Synchronizer: SYNC_STAGES-deep flop chain; syncOut is the last stage.
- Per-channel FSM with counter cnt, width $clog2(DEBOUNCE_CYCLES)+1:
  - RELEASED: syncOut=1 -> PRESS_CHK, cnt<=0.
  - PRESS_CHK: syncOut=0 -> RELEASED (glitch rejected, no pulse). Else, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED with keyPress<=1; otherwise cnt++.
  - PRESSED: syncOut=0 -> RELEASE_CHK, cnt<=0.
  - RELEASE_CHK: syncOut=1 -> PRESSED (no pulse). Else, if cnt==DEBOUNCE_CYCLES-1 -> RELEASED with keyRelease<=1; otherwise cnt++.
- keyLevel=1 exactly while the state is PRESSED or RELEASE_CHK, registered together with the state.
- Latency: a pin change first sampled at edge 1 and held stable yields its pulse and keyLevel change after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults 2/16, that is edge 19.
- Pulse width: exactly one cycle. A pulse never repeats without an intervening opposite accepted transition (unless AUTOREPEAT_EN).
- Bouncing during a CHK state restarts qualification from the stable state; the counter never wraps.
- DEBOUNCE_CYCLES=1: the CHK state lasts exactly one cycle.
- rst mid-operation: abort to reset values immediately; no pulse is emitted for an aborted qualification.
- Key held through reset: treated as a fresh press after rst deasserts, with full latency.

Optional Feature:
- Macro: IO_KEY_AUTOREPEAT_EN.
- Defined: each channel adds a repeat counter that clears on entering PRESSED. While the state stays PRESSED, keyPress pulses again REPEAT_DELAY cycles after the entry pulse, then every REPEAT_PERIOD cycles. Leaving PRESSED (including into RELEASE_CHK) clears the counter; a bounce back to PRESSED restarts the full REPEAT_DELAY. keyLevel and keyRelease are unaffected.
- Undefined: no repeat logic is synthesized; REPEAT_* parameters are ignored; exactly one keyPress per accepted press.

Decomposition:
- Types package additions:
  - KEY_NUM=3
  - KEY_CH=0, KEY_CE=1, KEY_CP=2
  - typedef KeyVector (logic [KEY_NUM-1:0])
  - enum KeyState {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}
- Sub-module io_key_channel holds the synchronizer, FSM, counters and optional repeat logic for one key.
- io_key_conditioner instantiates io_key_channel three times and packs the outputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: rst=1 for 3 cycles with all keys high -> all outputs 0. Release rst with keys still held -> all three keyPress bits pulse together after edge 7 following rst low.
- Clean press: sigCH 0->1, held 20 cycles -> keyPress=3'b001 for one cycle after edge 7; keyLevel[0]=1 from the same edge; keyRelease stays 0.
- Glitch reject: sigCE high for 3 cycles, then low -> keyLevel, keyPress and keyRelease remain 0 throughout.
- Release with bounce: sigCH held pressed, then goes 0 for 2 cycles, 1 for 1 cycle, then 0 steadily -> exactly one keyRelease[0] pulse, 7 edges after the final fall; keyLevel[0] drops on that edge.
- Mid-qualification reset: sigCP rises, rst pulsed at edge 5 -> no keyPress[2]. With sigCP still high, keyPress[2] pulses after edge 7 following rst deassertion.
- Auto-repeat (IO_KEY_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5): sigCH held 40 cycles -> keyPress[0] at entry T, then at T+10, T+15, T+20, T+25, T+30; none after release is accepted.
